// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundles the writeback requests, issue/decode queries and register-file write port
// master: drives ALU/LSU requests, issue and source queries; slave: returns readies, busy flags, write port, forwards
interface regfile_wb_arbiter_if;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  Rs1, Rs2;
  logic        rs1_busy, rs2_busy;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd, Rs1, Rs2,
    input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy, RegWrite, Rd, Write_data,
           fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd, Rs1, Rs2,
    output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy, RegWrite, Rd, Write_data,
           fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU and tracks pending writes
// Ports: clk, reset (sync, active-high); bus (slave) carries ALU/LSU requests + readies, issue handshake,
// Rs1/Rs2 busy queries, registered RegWrite/Rd/Write_data and optional forwards.
// Define WB_FWD_EN to forward the write-cycle data to decode; otherwise fwd* outputs are tied 0.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  logic [31:0] busy_q, busy_d, set_m, clr_m;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic regwrite_q, regwrite_d;
  logic [4:0] rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic alu_req, lsu_req, alu_gnt, lsu_gnt, starved, issue_ok, fwd1_hit, fwd2_hit;
  always_comb begin
    alu_req = bus.alu_valid & (bus.alu_rd != 5'd0);
    lsu_req = bus.lsu_valid & (bus.lsu_rd != 5'd0);
    starved = starve_cnt_q == CNT_W'(STARVE_LIMIT);
    alu_gnt = alu_req & (!lsu_req | starved);
    lsu_gnt = lsu_req & !alu_gnt;
    starve_cnt_d = (alu_req & !alu_gnt) ? (starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1)) : '0;
    regwrite_d = alu_gnt | lsu_gnt;
    rd_d = alu_gnt ? bus.alu_rd : lsu_gnt ? bus.lsu_rd : rd_q;
    wdata_d = alu_gnt ? bus.alu_data : lsu_gnt ? bus.lsu_data : wdata_q;
    // a register being written this cycle is about to go free, so a new issue to it may proceed
    issue_ok = !busy_q[bus.issue_rd] | (regwrite_q & (rd_q == bus.issue_rd)) | (bus.issue_rd == 5'd0);
    clr_m = regwrite_q ? 32'd1 << rd_q : '0;
    set_m = (bus.issue_valid & issue_ok) ? 32'd1 << bus.issue_rd : '0;
    // set applied after clear so a same-cycle issue keeps the entry busy; x0 never pends
    busy_d = ((busy_q & ~clr_m) | set_m) & ~32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      starve_cnt_q <= '0;
      regwrite_q <= 1'b0;
      rd_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      regwrite_q <= regwrite_d;
      rd_q <= rd_d;
      wdata_q <= wdata_d;
    end
  end
`ifdef WB_FWD_EN
  assign fwd1_hit = regwrite_q & (rd_q != 5'd0) & (rd_q == bus.Rs1);
  assign fwd2_hit = regwrite_q & (rd_q != 5'd0) & (rd_q == bus.Rs2);
  assign bus.fwd1_data = fwd1_hit ? wdata_q : '0;
  assign bus.fwd2_data = fwd2_hit ? wdata_q : '0;
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_data = '0;
`endif
  assign bus.fwd1_valid = fwd1_hit;
  assign bus.fwd2_valid = fwd2_hit;
  // x0 requests are acknowledged without arbitrating; nothing is accepted while in reset
  assign bus.alu_ready = !reset & (alu_gnt | (bus.alu_valid & (bus.alu_rd == 5'd0)));
  assign bus.lsu_ready = !reset & (lsu_gnt | (bus.lsu_valid & (bus.lsu_rd == 5'd0)));
  assign bus.issue_ready = issue_ok;
  assign bus.rs1_busy = busy_q[bus.Rs1] & !fwd1_hit;
  assign bus.rs2_busy = busy_q[bus.Rs2] & !fwd2_hit;
  assign bus.RegWrite = regwrite_q;
  assign bus.Rd = rd_q;
  assign bus.Write_data = wdata_q;
endmodule
